// File: rtl/mux_rr_arb_if.sv
// mux_rr_arb_if: handshake bundle between requesters, the arbitrating mux and
// the single downstream consumer.
//   in/in_valid/in_ready : M flattened N-bit request channels (channel i at [i*N +: N])
//   mode                 : 0 = round-robin, 1 = fixed priority (lowest index wins)
//   out/out_sel/out_valid/out_ready : registered output word, its source index, handshake
// Modports: master = requester/consumer side, slave = the mux.
interface mux_rr_arb_if #(
  parameter int N = 32,
  parameter int M = 8,
  parameter int S = $clog2(M)
);
  logic [M*N-1:0] in;
  logic [M-1:0]   in_valid;
  logic [M-1:0]   in_ready;
  logic           mode;
  logic [N-1:0]   out;
  logic [S-1:0]   out_sel;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output in, in_valid, mode, out_ready,
    input  in_ready, out, out_sel, out_valid
  );

  modport slave (
    input  in, in_valid, mode, out_ready,
    output in_ready, out, out_sel, out_valid
  );
endinterface

// File: rtl/mux_rr_arb.sv
// mux_rr_arb: M-input, N-bit arbitrating multiplexer with a registered output.
// A rotating-priority arbiter (or fixed lowest-index priority when mode = 1)
// picks one valid channel per cycle; the accepted word appears on out one
// cycle later. Full throughput when out_ready stays high.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mux_rr_arb_if.slave (channel inputs, mode, registered output handshake)
module mux_rr_arb #(
  parameter int N = 32,
  parameter int M = 8
) (
  input logic         clk,
  input logic         rst_n,
  mux_rr_arb_if.slave bus
);
  localparam int S = $clog2(M);

  logic [N-1:0] out_q;
  logic [S-1:0] sel_q;
  logic         valid_q;
  logic [S-1:0] ptr;

  logic [N-1:0] chan [M];
  logic [S-1:0] grant;
  logic [S-1:0] idx_s;
  logic         found;
  logic         load;
  logic         xfer;
  int unsigned  base;
  int unsigned  idx;

  always_comb begin
    for (int unsigned i = 0; i < M; i++) begin
      chan[i] = bus.in[i*N +: N];
    end
  end

  // Scan upward from the start point with wrap; fixed mode simply starts at 0,
  // which yields the lowest-index valid channel.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    idx_s = '0;
    base  = bus.mode ? 0 : 32'(ptr);
    for (int unsigned k = 0; k < M; k++) begin
      idx = base + k;
      if (idx >= 32'(M)) idx = idx - 32'(M);
      idx_s = S'(idx);
      if (!found && bus.in_valid[idx_s]) begin
        found = 1'b1;
        grant = idx_s;
      end
    end
  end

  assign load = !valid_q || bus.out_ready;
  assign xfer = rst_n && load && found;

  always_comb begin
    bus.in_ready = '0;
    if (xfer) bus.in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr     <= '0;
    end else if (xfer) begin
      out_q   <= chan[grant];
      sel_q   <= grant;
      valid_q <= 1'b1;
      if (!bus.mode) ptr <= (grant == S'(M-1)) ? '0 : grant + 1'b1;
    end else if (load) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_mux_rr_arb.sv
module tb_mux_rr_arb;
  localparam int N = 32;
  localparam int M = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  mux_rr_arb_if #(.N(N), .M(M)) bus ();
  mux_rr_arb #(.N(N), .M(M)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq_a [5];
    seq_a = '{1, 7, 1, 7, 1};
    rst_n         = 1'b0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 8'hFF;
    for (int i = 0; i < M; i++) bus.in[i*N +: N] = 32'hA0 + 32'(i);

    // reset held two cycles with every channel requesting
    step();
    step();
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out", bus.out, 0);
    check_eq("rst_out_sel", bus.out_sel, 0);
    check_eq("rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    #1;
    check_eq("first_grant", bus.in_ready, 8'h01);

    // round-robin rotation 0..7,0
    for (int i = 0; i < 9; i++) begin
      step();
      check_eq("rr_sel", bus.out_sel, i % 8);
      check_eq("rr_data", bus.out, 32'hA0 + 32'(i % 8));
      check_eq("rr_valid", bus.out_valid, 1);
    end

    // sparse wrap from a fresh pointer
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.in_valid = 8'b1000_0010;
    check_eq("sparse_ptr0", dut.ptr, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("sparse_sel", bus.out_sel, seq_a[i]);
      check_eq("sparse_data", bus.out, 32'hA0 + 32'(seq_a[i]));
      if (seq_a[i] == 7) check_eq("sparse_wrap_ptr", dut.ptr, 0);
    end

    // fixed priority: channel 2 always wins, pointer frozen at 2
    bus.mode = 1'b1;
    bus.in_valid = 8'b0011_0100;
    #1;
    check_eq("fix_ready0", bus.in_ready, 8'h04);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("fix_sel", bus.out_sel, 2);
      check_eq("fix_ready", bus.in_ready, 8'h04);
      check_eq("fix_ptr_hold", dut.ptr, 2);
    end

    // backpressure after capturing DEADBEEF from channel 3
    bus.mode = 1'b0;
    bus.in[3*N +: N] = 32'hDEAD_BEEF;
    bus.in_valid = 8'b0000_1000;
    step();
    check_eq("bp_cap_data", bus.out, 32'hDEAD_BEEF);
    check_eq("bp_cap_sel", bus.out_sel, 3);
    bus.out_ready = 1'b0;
    bus.in_valid = 8'b0001_1000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("bp_ready", bus.in_ready, 0);
      step();
      check_eq("bp_data", bus.out, 32'hDEAD_BEEF);
      check_eq("bp_sel", bus.out_sel, 3);
      check_eq("bp_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", bus.in_ready, 8'h10);
    step();
    check_eq("bp_next_data", bus.out, 32'hA4);
    check_eq("bp_next_sel", bus.out_sel, 4);

    // reset while holding a word with ptr = 5
    check_eq("mid_ptr5", dut.ptr, 5);
    check_eq("mid_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    bus.in_valid = 8'b0110_0000;
    step();
    check_eq("mid_rst_valid", bus.out_valid, 0);
    check_eq("mid_rst_ptr", dut.ptr, 0);
    check_eq("mid_rst_out", bus.out, 0);
    rst_n = 1'b1;
    #1;
    check_eq("mid_post_ready", bus.in_ready, 8'h20);
    step();
    check_eq("mid_post_sel", bus.out_sel, 5);
    check_eq("mid_post_data", bus.out, 32'hA5);

    // drain with no requests: valid drops, data holds
    bus.in_valid = '0;
    step();
    check_eq("drain_valid", bus.out_valid, 0);
    check_eq("drain_hold", bus.out, 32'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_rr_arb.md
# mux_rr_arb

Parametrised M-input, N-bit round-robin arbitrating multiplexer with a valid/ready handshake on every input and a registered output stage. It is the sequential successor to the fixed 8-to-1 select-driven mux tree. The select is generated internally by a rotating-priority arbiter, or by fixed priority when `mode` is set. It sits between multiple requesters (e.g. memory/bus clients) and a single shared consumer.

## Interface
Parameters:
- `N`, default 32: data width per channel.
- `M`, default 8: number of input channels; legal range 2..32, power of two not required.
- `S`, default `$clog2(M)`: select/index width; derived, not overridden.

Ports:
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `in`, input, M*N: flattened channel data; channel i occupies bits [i*N +: N].
- `in_valid`, input, M: per-channel request/valid.
- `in_ready`, output, M: per-channel accept; at most one bit high in any cycle.
- `mode`, input, 1: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `out`, output, N: registered data of the accepted channel.
- `out_sel`, output, S: registered index of the channel that produced `out`.
- `out_valid`, output, 1: output register holds a valid word.
- `out_ready`, input, 1: consumer accepts `out` this cycle.

## Operation
- Internal state: output register (`out`, `out_sel`, `out_valid`), round-robin pointer `ptr` (S bits, range 0..M-1).
- `load` = `!out_valid || out_ready` (register empty, or draining this cycle).
- Grant (combinational): in RR mode, the first `in_valid` bit at index ≥ `ptr`, scanning upward and wrapping from M-1 to 0. In fixed mode, the lowest-index `in_valid` bit; `ptr` is ignored.
- `in_ready[g]` = `load && any(in_valid)` for grant g; all other bits 0. `in_ready` does not depend on `in_valid[i]` of other channels beyond the grant choice.
- Transfer on channel g when `in_valid[g] && in_ready[g]`: next cycle `out` = channel g data, `out_sel` = g, `out_valid` = 1.
- When `load` is true and there is no transfer, `out_valid` goes to 0 next cycle. `out`/`out_sel` hold their last value.
- When `out_valid && !out_ready`: `out`, `out_sel` and `out_valid` hold; all `in_ready` = 0 (backpressure).
- Pointer: after a transfer in RR mode, `ptr` <= g+1, or 0 when g = M-1. In fixed mode `ptr` holds. Switching `mode` mid-stream takes effect on the grant in the same cycle; no flush.
- Inputs must hold data stable while valid and not yet accepted (upstream contract). The block does not check this.
- Simultaneous drain and load: a word is consumed and a new word is captured in the same cycle, giving full throughput of one word per cycle.

## Timing
- Reset (`rst_n` = 0 at an edge): `out` = 0, `out_sel` = 0, `out_valid` = 0, `ptr` = 0. While `rst_n` is low, `in_ready` = 0. Reset mid-transfer discards the held word; no partial state survives.
- Latency: input accepted in cycle t appears on `out`/`out_valid` in cycle t+1.
- Throughput: 1 word/cycle with `out_ready` held high.
- Fairness: in RR mode with all M inputs valid continuously, each channel is granted exactly once per M consecutive transfers.
- No combinational path from `in_valid`/`in` to `out`/`out_valid`. The combinational path from `out_ready` and `in_valid` to `in_ready` is allowed.

## Test plan
- Reset: drive `rst_n` = 0 for 2 cycles with all `in_valid` = 8'hFF. Required: `out_valid` = 0, `out` = 0, `out_sel` = 0, `in_ready` = 0. After release, the first grant is channel 0.
- RR rotation (M = 8, N = 32, `mode` = 0): all `in_valid` = 1, channel i data = 32'hA0+i, `out_ready` = 1. Required: `out_sel` sequence 0,1,…,7,0 on consecutive cycles, and `out` matches each index.
- Sparse wrap: `in_valid` = 8'b1000_0010, `ptr` starting at 0. Required: grants 1, 7, 1, 7, …; `ptr` wraps 7→0 and channel 1 is next.
- Fixed priority: `mode` = 1, `in_valid` = 8'b0011_0100 held. Required: channel 2 granted every cycle; channels 4 and 5 see `in_ready` = 0 throughout.
- Backpressure: `out_ready` = 0 for 3 cycles after a capture of 32'hDEAD_BEEF from channel 3. Required: `out`/`out_sel` = 32'hDEAD_BEEF/3 stable, and all `in_ready` = 0. When `out_ready` rises, the next word is captured in the same cycle.
- Reset mid-stream: assert `rst_n` = 0 while `out_valid` = 1 and `ptr` = 5. Required: the next cycle shows `out_valid` = 0 and `ptr` = 0, and the first post-reset grant goes to the lowest valid index.
